quebra_cadeado: RTL and testbench
=================================

Name: quebra_cadeado

Overview:
- Initiator-side driver for the combination-lock block: generates the `{a,b,c,d}` symbol sequences that the lock consumes and watches the lock's `aberto` output.
- Brute-forces every candidate code of `CODE_LEN` 4-bit symbols in ascending order, resetting the lock between attempts.
- Reports the first code that opens the lock, or failure once the space is exhausted.
- Sits beside `cadeado` in the lock exercises; used as bench stimulus and as a synthesizable demo.

Parameters:
- `CODE_LEN`, 3, symbols per attempt; candidate width `CW = 4*CODE_LEN`.
- `HOLD_CYC`, 1, cycles each symbol is held on `a..d` (≥1).
- `SETTLE_CYC`, 2, cycles waited after the last symbol before judging (≥1).

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a search; ignored while `busy`.
- `aberto` input 1: lock-open indication from the lock under test.
- `a`, `b`, `c`, `d` output 1 each: symbol bits; `{a,b,c,d} = symbol[3:0]`.
- `lock_rst_n` output 1: active-low reset to the lock, pulsed before every attempt.
- `busy` output 1: search in progress.
- `found` output 1: sticky; opening code located.
- `fail` output 1: sticky; space exhausted without opening.
- `code_out` output CW: winning candidate; valid while `found`.
- `attempts` output CW+1: completed attempts since `start`.

Behaviour:
- Reset values (async, on `rst_n` low):
  - `a..d=0`, `lock_rst_n=0`, `busy=0`, `found=0`, `fail=0`, `code_out=0`, `attempts=0`.
  - Candidate = 0, FSM = IDLE.
- All outputs are registered.
- States: IDLE, RST_LOCK, DRIVE, GAP, WAIT, CHECK, DONE.
- IDLE:
  - `lock_rst_n=1`, `a..d=0`.
  - `start=1` → RST_LOCK. In the same edge: clear `found`/`fail`/`attempts`, candidate=0, `busy=1`.
- RST_LOCK:
  - 1 cycle, `lock_rst_n=0`, `a..d=0`.
  - Clear the hit flag; symbol index=0 → DRIVE.
- DRIVE:
  - Drive symbol[index] for `HOLD_CYC` cycles → GAP.
  - Symbol 0 is `candidate[CW-1 -: 4]`, i.e. MSB nibble first.
- GAP:
  - 1 cycle, `a..d=0`, giving an edge between equal consecutive symbols.
  - If index==CODE_LEN-1 → WAIT; else index+1 → DRIVE.
- WAIT: `SETTLE_CYC` cycles, `a..d=0` → CHECK.
- Hit flag: set whenever `aberto=1` is sampled in DRIVE, GAP or WAIT.
- CHECK: 1 cycle, `attempts` +1, then:
  - hit → DONE with `found=1`, `code_out=candidate`.
  - else candidate == all-ones → DONE with `fail=1`.
  - else candidate +1 → RST_LOCK.
- DONE:
  - `busy=0`, `a..d=0`, `lock_rst_n=1`.
  - Flags hold; `start` re-launches exactly as from IDLE.
- Attempt length = `2 + CODE_LEN*(HOLD_CYC+1) + SETTLE_CYC` cycles. Defaults give 10.
- Candidate wrap-around never happens: all-ones terminates the search.
- `aberto` asserted during RST_LOCK or CHECK is ignored (lock is held in reset there).
- `start` while `busy`: no effect.
- `rst_n` asserted mid-search: immediate return to reset values. No partial `found` survives.

Optional Feature:
- Macro: `QUEBRA_CADEADO_MAX_TRIES_EN`.
- Defined:
  - Adds parameter `MAX_TRIES` (default 16).
  - In CHECK with no hit, if `attempts+1 == MAX_TRIES` → DONE with `fail=1`, even though candidates remain.
  - Hit takes priority over the limit.
- Undefined: the parameter is absent and the search runs the full `2^CW` candidates.

Decomposition:
- Package `cadeado_pkg`:
  - FSM state enum `quebra_state_t`.
  - Symbol width constant `SYM_W=4`.
  - Idle symbol constant `SYM_IDLE=4'b0000`.
- Sub-module `quebra_timer`:
  - Loadable down-counter with `load`, `value`, `zero` outputs.
  - Reused for `HOLD_CYC` and `SETTLE_CYC` countdowns.
- Candidate register, index counter and flags stay in the top level.

Test Plan:
- Reset then idle: hold `rst_n=0` for 3 cycles, release → all outputs at reset values; `busy` stays 0 with no `start`.
- Code 0x000: the bench lock model opens on three zero symbols; pulse `start` → `found=1`, `code_out=12'h000`, `attempts=1`, `busy` falls 10 cycles after `start`.
- Code 0x3A5: lock opens on 3,A,5; pulse `start` → `found=1`, `code_out=12'h3A5`, `attempts=0x3A6`, symbol order on `a..d` is 3,0,A,0,5,0.
- Never-open lock (`aberto` tied 0): pulse `start` → `fail=1`, `attempts=4096`, `found=0`, `busy=0`.
- Mid-search reset: assert `rst_n=0` during DRIVE of attempt 5 → outputs return to reset values asynchronously; a new `start` restarts from candidate 0.
- With `QUEBRA_CADEADO_MAX_TRIES_EN` and `MAX_TRIES=16`, lock code 0x020: pulse `start` → `fail=1` after `attempts=16`; `start` pulsed while `busy` has no effect on `attempts`.

Source files
------------

// File: rtl/cadeado_pkg.sv
// Shared types and constants for the combination-lock exercises: the
// brute-force driver's state encoding and symbol conventions.
package cadeado_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOCK,
        ST_DRIVE,
        ST_GAP,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } quebra_state_t;

    localparam int SYM_W = 4;
    localparam logic [SYM_W-1:0] SYM_IDLE = 4'b0000;

    function automatic int max_i(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/quebra_timer.sv
// Loadable down-counter used for symbol hold and post-sequence settle delays.
// 'zero' is high once the loaded count has been consumed.
module quebra_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/quebra_cadeado.sv
// Brute-force driver for the combination lock: plays every CODE_LEN-symbol
// candidate in ascending order and reports the first one that opens it.
// Optional attempt cap: define QUEBRA_CADEADO_MAX_TRIES_EN (adds MAX_TRIES).
module quebra_cadeado
    import cadeado_pkg::*;
#(
    parameter int CODE_LEN   = 3,
    parameter int HOLD_CYC   = 1,
`ifdef QUEBRA_CADEADO_MAX_TRIES_EN
    parameter int SETTLE_CYC = 2,
    parameter int MAX_TRIES  = 16
`else
    parameter int SETTLE_CYC = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  aberto,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  lock_rst_n,
    output logic                  busy,
    output logic                  found,
    output logic                  fail,
    output logic [4*CODE_LEN-1:0] code_out,
    output logic [4*CODE_LEN:0]   attempts
);

    localparam int CW = SYM_W * CODE_LEN;
    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TW = $clog2(max_i(HOLD_CYC, SETTLE_CYC) + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(CODE_LEN - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);

    quebra_state_t    state_q, state_d;
    logic [CW-1:0]    cand_q, cand_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             hit_q, hit_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             lock_rst_n_q, lock_rst_n_d;
    logic             busy_q, busy_d;
    logic             found_q, found_d;
    logic             fail_q, fail_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CW:0]      att_q, att_d;
    logic [CW:0]      att_inc;

    logic             tmr_load;
    logic [TW-1:0]    tmr_value;
    logic             tmr_zero;

    quebra_timer #(
        .W (TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    assign att_inc = att_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        busy_d    = busy_q;
        found_d   = found_q;
        fail_d    = fail_q;
        code_d    = code_q;
        att_d     = att_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        // Any sighting of 'aberto' while the sequence is in flight counts.
        if (aberto && (state_q == ST_DRIVE || state_q == ST_GAP || state_q == ST_WAIT)) begin
            hit_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    found_d = 1'b0;
                    fail_d  = 1'b0;
                    att_d   = '0;
                    cand_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RST_LOCK;
                end
            end
            ST_RST_LOCK: begin
                hit_d     = 1'b0;
                idx_d     = '0;
                tmr_load  = 1'b1;
                tmr_value = HOLD_LOAD;
                state_d   = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (tmr_zero) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                tmr_load = 1'b1;
                if (idx_q == LAST_IDX) begin
                    tmr_value = SETTLE_LOAD;
                    state_d   = ST_WAIT;
                end else begin
                    tmr_value = HOLD_LOAD;
                    idx_d     = idx_q + 1'b1;
                    state_d   = ST_DRIVE;
                end
            end
            ST_WAIT: begin
                if (tmr_zero) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                att_d = att_inc;
                if (hit_q) begin
                    found_d = 1'b1;
                    code_d  = cand_q;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (cand_q == '1) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
`ifdef QUEBRA_CADEADO_MAX_TRIES_EN
                end else if (att_inc == (CW+1)'(MAX_TRIES)) begin
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
`endif
                end else begin
                    cand_d  = cand_q + 1'b1;
                    state_d = ST_RST_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Symbol 0 is the most significant nibble of the candidate.
    logic [SYM_W-1:0] cand_syms [CODE_LEN];

    generate
        for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_sym
            assign cand_syms[gi] = cand_d[CW-1-SYM_W*gi -: SYM_W];
        end
    endgenerate

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        sym_d        = SYM_IDLE;
        lock_rst_n_d = (state_d != ST_RST_LOCK);
        if (state_d == ST_DRIVE) begin
            sym_d = cand_syms[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            sym_q        <= SYM_IDLE;
            lock_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            fail_q       <= 1'b0;
            code_q       <= '0;
            att_q        <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            idx_q        <= idx_d;
            hit_q        <= hit_d;
            sym_q        <= sym_d;
            lock_rst_n_q <= lock_rst_n_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            fail_q       <= fail_d;
            code_q       <= code_d;
            att_q        <= att_d;
        end
    end

    assign {a, b, c, d} = sym_q;
    assign lock_rst_n   = lock_rst_n_q;
    assign busy         = busy_q;
    assign found        = found_q;
    assign fail         = fail_q;
    assign code_out     = code_q;
    assign attempts     = att_q;

endmodule

// File: tb/tb_quebra_cadeado.sv
// Self-checking bench for quebra_cadeado: a positional lock model answers the
// driver, and a scoreboard holds the expected outcome of each search.
module tb_quebra_cadeado;

    localparam int CW     = 12;
    localparam int BUDGET = 60000;
`ifdef QUEBRA_CADEADO_MAX_TRIES_EN
    localparam int LIMIT  = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          aberto = 1'b0;
    logic          a, b, c, d;
    logic          lock_rst_n, busy, found, fail;
    logic [CW-1:0] code_out;
    logic [CW:0]   attempts;

    quebra_cadeado dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .aberto     (aberto),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .lock_rst_n (lock_rst_n),
        .busy       (busy),
        .found      (found),
        .fail       (fail),
        .code_out   (code_out),
        .attempts   (attempts)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Lock model: after release, symbol i is expected at cycle 2*i (hold 1 + gap 1);
    // it opens right after the third matching symbol and stays open until reset.
    logic [CW-1:0] lock_code  = '0;
    bit            lock_never = 1'b0;
    int            k = 0;
    bit            match = 1'b1;
    logic [3:0]    seq [6];
    logic [CW-1:0] sym_exp;

    always @(negedge clk) begin
        if (!lock_rst_n) begin
            k      = 0;
            match  = 1'b1;
            aberto = 1'b0;
        end else begin
            if (k < 6) begin
                seq[k] = {a, b, c, d};
                if (k % 2 == 0) begin
                    sym_exp = lock_code >> (4 * (2 - k / 2));
                    if ({a, b, c, d} != sym_exp[3:0]) match = 1'b0;
                    if (k == 4 && match && !lock_never) aberto = 1'b1;
                end
            end
            if (k < 1000) k++;
        end
    end

    typedef struct {
        bit          found;
        bit          fail;
        logic [CW-1:0] code;
        logic [CW:0]   att;
    } exp_t;

    exp_t sb[$];

    task automatic run(input string tag, input logic [CW-1:0] code, input bit never);
        exp_t e;
        int   lat;
        lock_code  = code;
        lock_never = never;
        e.code = code;
        if (never) begin
            e.found = 1'b0; e.fail = 1'b1; e.att = 13'd4096;
        end else begin
            e.found = 1'b1; e.fail = 1'b0; e.att = {1'b0, code} + 13'd1;
        end
`ifdef QUEBRA_CADEADO_MAX_TRIES_EN
        if (e.att > LIMIT) begin
            e.found = 1'b0; e.fail = 1'b1; e.att = 13'(LIMIT);
        end
`endif
        sb.push_back(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 0;
        // A stray start pulse mid-search must not disturb anything.
        while (busy && lat < BUDGET) begin
            lat++;
            start = (lat == 25);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_timeout"}, 64'(busy), 64'd0);
        e = sb.pop_front();
        chk({tag, "_found"}, 64'(found), 64'(e.found));
        chk({tag, "_fail"}, 64'(fail), 64'(e.fail));
        chk({tag, "_attempts"}, 64'(attempts), 64'(e.att));
        chk({tag, "_cycles"}, 64'(lat), 64'(10 * int'(e.att)));
        if (e.found) chk({tag, "_code"}, 64'(code_out), 64'(e.code));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sym"}, 64'({a, b, c, d}), 64'd0);
        chk({tag, "_lock_rst_n"}, 64'(lock_rst_n), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_flags"}, 64'({found, fail}), 64'd0);
        chk({tag, "_code"}, 64'(code_out), 64'd0);
        chk({tag, "_attempts"}, 64'(attempts), 64'd0);
    endtask

    initial begin
        int wait_cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_lock_rst_n", 64'(lock_rst_n), 64'd1);

        run("c000", 12'h000, 1'b0);
`ifdef QUEBRA_CADEADO_MAX_TRIES_EN
        run("lim020", 12'h020, 1'b0);
        run("c00A", 12'h00A, 1'b0);
`else
        run("c3A5", 12'h3A5, 1'b0);
        chk("c3A5_seq", 64'({seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]}), 64'h30A050);
        run("never", 12'h000, 1'b1);
`endif

        // Reset mid-search during DRIVE of attempt 5.
        lock_code  = 12'h3A5;
        lock_never = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_cyc = 0;
        while (attempts != 13'd4 && wait_cyc < 1000) begin
            wait_cyc++;
            @(negedge clk);
        end
        chk("mid_reach4", 64'(attempts), 64'd4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("restart", 12'h002, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
